// File: rtl/verdict_uart_reporter.sv
// verdict_uart_reporter
//   Turns each grammar_fsm verdict into an ASCII line on a UART TX pin:
//   "ACK\r\n" (41 43 4B 0D 0A) on accept, "NAK\r\n" (4E 41 4B 0D 0A) on reject.
//   The 8N1 serializer is built in, LSB first, with CLKS_PER_BIT clocks per bit.
//   There is a one-deep pending slot, and the most recent verdict wins.
// Ports
//   clk         system clock
//   rst         synchronous active-high reset; aborts any frame in progress
//   accept      accept verdict, level or pulse; only the rising edge is used
//   reject      reject verdict, level or pulse; only the rising edge is used
//   tx          UART TX output, registered, idle high
//   busy        high while a message is being sent or is pending
//   drop_count  saturating count of overwritten verdicts
//               (this port exists only when VERDICT_DROP_CNT_EN is defined)
// Configuration
//   Define VERDICT_DROP_CNT_EN to add drop_count.
//   When it is not defined, an overflow still overwrites the pending slot, but nothing counts it.
module verdict_uart_reporter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
  input  logic       reject,
  output logic       tx,
  output logic       busy
`ifdef VERDICT_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_NEXT
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [2:0]    byte_idx, byte_nxt;
  logic          msg_rej, msg_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic          pend_rej, pend_rej_nxt;
  logic          accept_q, reject_q;
  logic          tx_nxt;
  logic [7:0]    cur_byte;
  logic          ev_acc, ev_rej, ev_any;
  logic          baud_done;

  // The history registers clear on reset.
  // Because of that, a level that is held high through reset release counts as one event.
  assign ev_acc = accept & ~accept_q;
  assign ev_rej = reject & ~reject_q;
  assign ev_any = ev_acc | ev_rej;   // when both fire, ev_rej selects NAK

  assign baud_done = (baud == BAUD_LAST);
  assign busy      = (state != S_IDLE) | pend_vld;

  function automatic logic [7:0] msg_byte(input logic rej, input logic [2:0] idx);
    case (idx)
      3'd0:    msg_byte = rej ? 8'h4E : 8'h41;
      3'd1:    msg_byte = rej ? 8'h41 : 8'h43;
      3'd2:    msg_byte = 8'h4B;
      3'd3:    msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      msg_rej  <= 1'b0;
      pend_vld <= 1'b0;
      pend_rej <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud     <= baud_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      msg_rej  <= msg_nxt;
      pend_vld <= pend_vld_nxt;
      pend_rej <= pend_rej_nxt;
      accept_q <= accept;
      reject_q <= reject;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    baud_nxt     = baud;
    bit_nxt      = bit_idx;
    byte_nxt     = byte_idx;
    msg_nxt      = msg_rej;
    pend_vld_nxt = pend_vld;
    pend_rej_nxt = pend_rej;

    case (state)
      S_IDLE: begin
        if (ev_any) begin
          msg_nxt   = ev_rej;
          byte_nxt  = '0;
          bit_nxt   = '0;
          baud_nxt  = '0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_nxt = '0;
          if (byte_idx == 3'd4) begin
            state_nxt = S_NEXT;
          end else begin
            byte_nxt  = byte_idx + 3'd1;
            state_nxt = S_START;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      S_NEXT: begin
        // An event that arrives during this cycle overwrites the slot.
        // The slot is then consumed straight away, so the last verdict is the one that gets sent.
        if (ev_any || pend_vld) begin
          msg_nxt      = ev_any ? ev_rej : pend_rej;
          pend_vld_nxt = 1'b0;
          byte_nxt     = '0;
          bit_nxt      = '0;
          baud_nxt     = '0;
          state_nxt    = S_START;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state != S_IDLE && state != S_NEXT && ev_any) begin
      pend_vld_nxt = 1'b1;
      pend_rej_nxt = ev_rej;
    end
  end

  // The tx bit is computed from the next state, so the registered pin lines up with the state register.
  always_comb begin
    cur_byte = msg_byte(msg_nxt, byte_nxt);
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = cur_byte[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

`ifdef VERDICT_DROP_CNT_EN
  // A new event that meets a full slot loses the older verdict.
  // In IDLE the slot is always empty.
  logic drop_evt;
  assign drop_evt = ev_any & pend_vld & (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst)                               drop_count <= 8'd0;
    else if (drop_evt && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule
